axis_wrapper_top: RTL and testbench
===================================

AXIS_WRAPPER_TOP -- requirements
Module: axis_wrapper_top

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; the clock port is s00_axis_aclk and the reset port is s00_axis_areset.
REQ-002 Parameter C_S00_AXIS_DATA_WIDTH, default 64, is the slave tdata width; only 64 is supported.
REQ-003 Parameter C_M00_AXIS_DATA_WIDTH, default 64, is the master tdata width; only 64 is supported.
REQ-004 Parameter NUM_PACKETS, default 13, is the number of input beats per datapoint (range 1..255).
REQ-005 Ports SHALL be:
- s00_axis_aclk  in  1  clock
- s00_axis_areset  in  1  synchronous active-high reset
- s00_axis_tdata  in  64  input feature beat
- s00_axis_tstrb  in  8  byte strobes; ignored
- s00_axis_tvalid  in  1  input beat valid
- s00_axis_tlast  in  1  last beat of the stream
- s00_axis_tready  out  1  block accepts an input beat
- m00_axis_tdata  out  64  result beat
- m00_axis_tvalid  out  1  result valid
- m00_axis_tlast  out  1  last result of the stream
- m00_axis_tready  in  1  downstream accepts the result

Function
REQ-006 An input beat SHALL be accepted on a rising edge where s00_axis_tvalid and s00_axis_tready are both 1.
REQ-007 A datapoint SHALL be NUM_PACKETS accepted beats, or fewer if an accepted beat carries tlast (early end).
REQ-008 Per datapoint, on every accepted beat the block SHALL update three registers:
- pcnt (16 bit) += popcount(tdata)
- xacc (64 bit) ^= tdata
- beat count += 1
REQ-009 States: RECV (s00_axis_tready=1) and SEND (s00_axis_tready=0, m00_axis_tvalid=1).
REQ-010 On the accepted beat that is the NUM_PACKETS-th beat or carries tlast, the block SHALL go RECV->SEND.
- The result SHALL be valid in the next cycle (latency 1 cycle after the final beat).
REQ-011 Result format: m00_axis_tdata = {idx[15:0], pcnt[15:0], xacc[63:32]^xacc[31:0]}.
- idx is the datapoint index within the current stream.
REQ-012 m00_axis_tlast SHALL be 1 exactly when the datapoint's final beat carried s00_axis_tlast.
REQ-013 In SEND, m00_axis_tdata and m00_axis_tlast SHALL be held stable until m00_axis_tready=1.
- On that handshake the block SHALL return to RECV in the next cycle.
- pcnt, xacc and beat count SHALL be cleared.
REQ-014 idx SHALL increment after each result handshake.
- It SHALL reset to 0 after a handshake with m00_axis_tlast=1.
- It SHALL wrap modulo 2^16.
REQ-015 s00_axis_tready SHALL be registered. No input beat SHALL be accepted while a result is pending; there is no overlap.
REQ-016 tlast on the NUM_PACKETS-th beat SHALL produce one result, not two.

Reset
REQ-017 While reset is 1, outputs SHALL be: s00_axis_tready=0, m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0.
REQ-018 While reset is 1, state=RECV and all counters and accumulators SHALL be 0.
REQ-019 s00_axis_tready SHALL rise on the first edge after reset is deasserted.
REQ-020 A reset mid-datapoint or during SEND SHALL discard the partial or pending result without emitting it.

Structure
REQ-021 Package axis_wrapper_pkg SHALL hold the data-width constants, the NUM_PACKETS default, the result field offsets and the state enum.
REQ-022 A sub-module packet_accumulator SHALL hold pcnt, xacc and beat count, with load-clear and accept inputs.
- The top SHALL hold the FSM, idx and the AXIS output registers.

Verification
REQ-023 Reset: hold reset 3 cycles -> all outputs 0; s00_axis_tready=1 one cycle after release.
REQ-024 13 beats of 0xFFFF_FFFF_FFFF_FFFF, tlast on beat 13, m00_axis_tready=1 -> one result 0x0000_0340_0000_0000 with m00_axis_tlast=1, one cycle after beat 13.
REQ-025 130 beats (10 datapoints), tlast on beat 130 -> 10 results with idx 0..9 in tdata[63:48]; m00_axis_tlast only on the 10th result.
REQ-026 Backpressure: m00_axis_tready=0 for 5 cycles after a result -> tvalid and tdata held stable and s00_axis_tready=0; after the handshake, s00_axis_tready=1 the next cycle.
REQ-027 Early end: 5 beats of 0x1, tlast on beat 5 -> result 0x0000_0005_0000_0001 with tlast=1; the next datapoint has idx 0.
REQ-028 Reset after 7 beats of a datapoint -> no result emitted; then 13 beats of 0 -> result 0x0000_0000_0000_0000.

Source files
------------

// File: rtl/axis_wrapper_pkg.sv
// ---------------------------------------------------------------------------
// axis_wrapper_pkg
// Shared constants for the AXI-Stream feature wrapper:
//   - stream data widths and the default beats-per-datapoint
//   - accumulator and index widths
//   - bit offsets of the fields inside the 64-bit result word
//   - FSM state encoding
//   - fold_xor(): folds the 64-bit XOR accumulator into the 32-bit result field
// ---------------------------------------------------------------------------
package axis_wrapper_pkg;

  localparam int AXIS_DATA_W     = 64;
  localparam int NUM_PACKETS_DEF = 13;

  localparam int PCNT_W = 16;
  localparam int IDX_W  = 16;
  localparam int BCNT_W = 8;

  // Result word layout: {idx, pcnt, xacc[63:32] ^ xacc[31:0]}
  localparam int RES_IDX_LSB  = 48;
  localparam int RES_PCNT_LSB = 32;
  localparam int RES_XOR_LSB  = 0;
  localparam int RES_XOR_W    = 32;

  typedef enum logic {
    ST_RECV = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic logic [RES_XOR_W-1:0] fold_xor(input logic [AXIS_DATA_W-1:0] x);
    return x[AXIS_DATA_W-1:RES_XOR_W] ^ x[RES_XOR_W-1:0];
  endfunction

endpackage

// File: rtl/packet_accumulator.sv
// ---------------------------------------------------------------------------
// packet_accumulator
// Per-datapoint accumulators: population count, running XOR and beat count.
// The *_nxt outputs are the values including the beat being accepted this
// cycle, so the caller can capture a finished result on the final beat edge.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset (clears all accumulators)
//   clr       in   clear all accumulators (result handed off)
//   accept    in   a beat is being accepted this cycle
//   din       in   beat data
//   pcnt_nxt  out  popcount total including the current beat
//   xacc_nxt  out  XOR accumulator including the current beat
//   bcnt_nxt  out  beat count including the current beat
// ---------------------------------------------------------------------------
module packet_accumulator
  import axis_wrapper_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              accept,
  input  logic [DATA_W-1:0] din,
  output logic [PCNT_W-1:0] pcnt_nxt,
  output logic [DATA_W-1:0] xacc_nxt,
  output logic [BCNT_W-1:0] bcnt_nxt
);

  logic [PCNT_W-1:0] pcnt_p0;
  logic [DATA_W-1:0] xacc_p0;
  logic [BCNT_W-1:0] bcnt_p0;

  function automatic logic [PCNT_W-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [PCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c = c + {{(PCNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  always_comb begin
    pcnt_nxt = pcnt_p0;
    xacc_nxt = xacc_p0;
    bcnt_nxt = bcnt_p0;
    if (accept) begin
      pcnt_nxt = pcnt_p0 + popcount(din);
      xacc_nxt = xacc_p0 ^ din;
      bcnt_nxt = bcnt_p0 + BCNT_W'(1);
    end
  end

  // --- accumulator register stage ---
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pcnt_p0 <= '0;
      xacc_p0 <= '0;
      bcnt_p0 <= '0;
    end else begin
      pcnt_p0 <= pcnt_nxt;
      xacc_p0 <= xacc_nxt;
      bcnt_p0 <= bcnt_nxt;
    end
  end

endmodule

// File: rtl/axis_wrapper_top.sv
// ---------------------------------------------------------------------------
// axis_wrapper_top
// AXI-Stream wrapper that folds NUM_PACKETS input beats (or fewer when tlast
// arrives early) into one 64-bit result beat:
//   m00_axis_tdata = {idx[15:0], popcount_sum[15:0], xacc[63:32]^xacc[31:0]}
// Receive and send never overlap: while a result is pending the slave side
// is held not-ready.
//
// Ports:
//   s00_axis_aclk    in   clock
//   s00_axis_areset  in   synchronous active-high reset
//   s00_axis_tdata   in   input feature beat
//   s00_axis_tstrb   in   byte strobes (ignored)
//   s00_axis_tvalid  in   input beat valid
//   s00_axis_tlast   in   last beat of the stream
//   s00_axis_tready  out  block accepts an input beat (registered)
//   m00_axis_tdata   out  result beat
//   m00_axis_tvalid  out  result valid
//   m00_axis_tlast   out  last result of the stream
//   m00_axis_tready  in   downstream accepts the result
// ---------------------------------------------------------------------------
module axis_wrapper_top
  import axis_wrapper_pkg::*;
#(
  parameter int C_S00_AXIS_DATA_WIDTH = AXIS_DATA_W,
  parameter int C_M00_AXIS_DATA_WIDTH = AXIS_DATA_W,
  parameter int NUM_PACKETS           = NUM_PACKETS_DEF
) (
  input  logic                               s00_axis_aclk,
  input  logic                               s00_axis_areset,
  input  logic [C_S00_AXIS_DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                               s00_axis_tvalid,
  input  logic                               s00_axis_tlast,
  output logic                               s00_axis_tready,
  output logic [C_M00_AXIS_DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic                               m00_axis_tvalid,
  output logic                               m00_axis_tlast,
  input  logic                               m00_axis_tready
);

  state_t state_q, state_nxt;

  logic                             s_tready_p1;
  logic                             vld_p1;
  logic                             m_tlast_p1;
  logic [C_M00_AXIS_DATA_WIDTH-1:0] m_tdata_p1;
  logic [C_M00_AXIS_DATA_WIDTH-1:0] result_p0;
  logic [IDX_W-1:0]                 idx_q;

  logic beat_acc;
  logic final_beat;
  logic ld_res;
  logic acc_clr;

  logic [PCNT_W-1:0]                pcnt_nxt;
  logic [C_S00_AXIS_DATA_WIDTH-1:0] xacc_nxt;
  logic [BCNT_W-1:0]                bcnt_nxt;

  // Strobes carry no meaning for this block.
  logic unused_tstrb;
  assign unused_tstrb = ^s00_axis_tstrb;

  // The registered tready is only ever high in RECV, so it doubles as the
  // "state allows receive" qualifier for the handshake.
  assign beat_acc   = s00_axis_tvalid & s_tready_p1;
  // A tlast on the NUM_PACKETS-th beat hits both terms but still yields a
  // single transition, hence a single result.
  assign final_beat = beat_acc &
                      (s00_axis_tlast | (bcnt_nxt == BCNT_W'(NUM_PACKETS)));

  packet_accumulator #(
    .DATA_W (C_S00_AXIS_DATA_WIDTH)
  ) u_acc (
    .clk      (s00_axis_aclk),
    .rst      (s00_axis_areset),
    .clr      (acc_clr),
    .accept   (beat_acc),
    .din      (s00_axis_tdata),
    .pcnt_nxt (pcnt_nxt),
    .xacc_nxt (xacc_nxt),
    .bcnt_nxt (bcnt_nxt)
  );

  always_comb begin
    result_p0 = '0;
    result_p0[RES_IDX_LSB  +: IDX_W]     = idx_q;
    result_p0[RES_PCNT_LSB +: PCNT_W]    = pcnt_nxt;
    result_p0[RES_XOR_LSB  +: RES_XOR_W] = fold_xor(xacc_nxt);
  end

  always_comb begin
    state_nxt = state_q;
    ld_res    = 1'b0;
    acc_clr   = 1'b0;
    case (state_q)
      ST_RECV: begin
        if (final_beat) begin
          state_nxt = ST_SEND;
          ld_res    = 1'b1;
        end
      end
      ST_SEND: begin
        if (m00_axis_tready) begin
          state_nxt = ST_RECV;
          acc_clr   = 1'b1;
        end
      end
      default: state_nxt = ST_RECV;
    endcase
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q <= ST_RECV;
    end else begin
      state_q <= state_nxt;
    end
  end

  // --- output register stage ---
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      s_tready_p1 <= 1'b0;
      vld_p1      <= 1'b0;
      m_tlast_p1  <= 1'b0;
      m_tdata_p1  <= '0;
      idx_q       <= '0;
    end else begin
      s_tready_p1 <= (state_nxt == ST_RECV);
      vld_p1      <= (state_nxt == ST_SEND);
      if (ld_res) begin
        m_tdata_p1 <= result_p0;
        m_tlast_p1 <= s00_axis_tlast;
      end
      // acc_clr marks the result handshake; a stream end restarts numbering.
      if (acc_clr) begin
        idx_q <= m_tlast_p1 ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  assign s00_axis_tready = s_tready_p1;
  assign m00_axis_tvalid = vld_p1;
  assign m00_axis_tlast  = m_tlast_p1;
  assign m00_axis_tdata  = m_tdata_p1;

endmodule

// File: tb/tb_axis_wrapper_top.sv
module tb_axis_wrapper_top;

  logic        clk;
  logic        rst;
  logic [63:0] s_tdata;
  logic [7:0]  s_tstrb;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;

  int checks = 0;
  int errors = 0;
  int n_res  = 0;

  // Scoreboard entries: {tlast, tdata}
  logic [64:0] exp_q[$];

  // Reference model state
  logic [15:0] mdl_pcnt;
  logic [63:0] mdl_xacc;
  logic [15:0] mdl_idx;
  int          mdl_bcnt;

  axis_wrapper_top dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mdl_pcnt = '0;
    mdl_xacc = '0;
    mdl_bcnt = 0;
  endtask

  task automatic model_accept(input logic [63:0] d, input logic l);
    logic [31:0] fold;
    mdl_pcnt = mdl_pcnt + 16'($countones(d));
    mdl_xacc = mdl_xacc ^ d;
    mdl_bcnt = mdl_bcnt + 1;
    if (l || mdl_bcnt == 13) begin
      fold = mdl_xacc[63:32] ^ mdl_xacc[31:0];
      exp_q.push_back({l, mdl_idx, mdl_pcnt, fold});
      mdl_idx = l ? 16'd0 : mdl_idx + 16'd1;
      model_clear();
    end
  endtask

  // Drive one beat and return at #1 after the edge that accepted it.
  task automatic send_beat(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (s_tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("beat_tready_wait", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    model_accept(d, l);
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    exp_q.delete();
    model_clear();
    mdl_idx = '0;
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast",  64'(m_tlast),  64'd0);
    chk("rst_m_tdata",  m_tdata,       64'd0);
    rst = 1'b0;
    chk("rst_tready_before_edge", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    chk("tready_after_rst", 64'(s_tready), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: compare on every result handshake.
  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst && m_tvalid === 1'b1 && m_tready === 1'b1) begin
      n_res++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("res_tdata", m_tdata, e[63:0]);
        chk("res_tlast", 64'(m_tlast), 64'(e[64]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    logic [64:0] held;
    rst      = 1'b1;
    s_tdata  = '0;
    s_tstrb  = '1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    mdl_idx  = '0;
    model_clear();

    // Reset held for 3 cycles
    do_reset(3);

    // 13 beats of all-ones, tlast on beat 13
    for (int i = 0; i < 13; i++) send_beat(64'hFFFF_FFFF_FFFF_FFFF, i == 12);
    chk("ones_latency_tvalid", 64'(m_tvalid), 64'd1);
    chk("ones_tdata", m_tdata, 64'h0000_0340_0000_0000);
    chk("ones_tlast", 64'(m_tlast), 64'd1);
    chk("ones_tready_low", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    chk("ones_tvalid_drop", 64'(m_tvalid), 64'd0);
    chk("ones_tready_back", 64'(s_tready), 64'd1);
    drain();

    // 130 random beats = 10 datapoints, tlast on beat 130, with idle gaps
    base = n_res;
    for (int i = 0; i < 130; i++) begin
      send_beat({$urandom, $urandom}, i == 129);
      if (i % 9 == 8) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    chk("stream10_result_count", 64'(n_res - base), 64'd10);

    // Early end: 5 beats of 1, tlast on beat 5
    for (int i = 0; i < 5; i++) send_beat(64'h1, i == 4);
    chk("early_tvalid", 64'(m_tvalid), 64'd1);
    chk("early_tdata", m_tdata, 64'h0000_0005_0000_0001);
    chk("early_tlast", 64'(m_tlast), 64'd1);
    drain();

    // Backpressure: result held 5 cycles, no tlast so idx advances afterwards
    m_tready = 1'b0;
    for (int i = 0; i < 13; i++) send_beat(64'h0101_0101_0101_0101 * (i + 1), 1'b0);
    held = exp_q[0];
    chk("bp_first_idx0", {48'd0, m_tdata[63:48]}, 64'd0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_tvalid_held", 64'(m_tvalid), 64'd1);
      chk("bp_tdata_held",  m_tdata, held[63:0]);
      chk("bp_tlast_held",  64'(m_tlast), 64'(held[64]));
      chk("bp_s_tready_low", 64'(s_tready), 64'd0);
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_tready_after_hs", 64'(s_tready), 64'd1);
    chk("bp_tvalid_after_hs", 64'(m_tvalid), 64'd0);
    drain();

    // Following datapoint carries idx 1; tlast on beat 13 gives one result only
    for (int i = 0; i < 13; i++) send_beat(64'h8000_0000_0000_0003, i == 12);
    chk("idx1_field", {48'd0, m_tdata[63:48]}, 64'd1);
    drain();

    // Reset during SEND discards the pending result
    m_tready = 1'b0;
    for (int i = 0; i < 13; i++) send_beat(64'hA5A5_0000_FFFF_0001, 1'b0);
    chk("pending_tvalid", 64'(m_tvalid), 64'd1);
    m_tready = 1'b1;
    do_reset(2);
    chk("send_rst_no_valid", 64'(m_tvalid), 64'd0);

    // Reset after 7 beats discards the partial datapoint
    for (int i = 0; i < 7; i++) send_beat({$urandom, $urandom}, 1'b0);
    base = n_res;
    do_reset(2);
    repeat (3) @(posedge clk);
    #1;
    chk("partial_no_result", 64'(n_res - base), 64'd0);
    for (int i = 0; i < 13; i++) send_beat(64'h0, i == 12);
    chk("zero_tvalid", 64'(m_tvalid), 64'd1);
    chk("zero_tdata", m_tdata, 64'h0);
    chk("zero_tlast", 64'(m_tlast), 64'd1);
    drain();

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
